packet_parser: RTL and testbench

Parametrised packet front-end between the show-ahead packet FIFO and the command decoder. It pops one wide packet at a time and checks its header (magic byte and length bound). It extracts the opcode, length and a length-masked payload window, then presents the result to downstream over a valid/ready handshake with backpressure. Malformed packets are dropped, flagged and counted.

---
 rtl/packet_parser.sv | 189 ++++++++++++++++++
 tb/tb_packet_parser.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_parser.sv
// rtl/packet_parser.sv - header check, field extraction and handshake for show-ahead FIFO packets
//
// Purpose: pops one wide packet at a time from a show-ahead FIFO, checks the
// header magic and length bound, and presents opcode, length and a
// length-masked payload window downstream over a valid/ready handshake.
// Malformed packets are popped and dropped, with a pulse, a sticky code and
// a saturating count.
//
// Ports:
//   CLK, rst            clock, asynchronous active-high reset
//   fifo_empty          FIFO empty flag
//   fifo_data           head-of-FIFO packet, byte k at [8*k +: 8]
//   rd_en               one-cycle pop pulse
//   out_valid/out_ready downstream handshake
//   opcode, payload_len extracted header fields (length as received)
//   payload             payload window, bytes at index >= payload_len are zero
//   err_pulse           one-cycle pulse per dropped packet
//   err_code            {len too large, magic mismatch}, held until next error
//   err_count           saturating dropped-packet count
//
// Build option: PKT_PARSER_CHECK_EN enables the header checks, the SKIP state
// and the error outputs. Without it every packet is accepted and the error
// outputs are tied to zero.
module packet_parser #(
  parameter int         SIZE          = 256,
  parameter int         MAGIC_BYTE    = 0,
  parameter logic [7:0] MAGIC         = 8'hA5,
  parameter int         LEN_BYTE      = 1,
  parameter int         OPCODE_BYTE   = 2,
  parameter int         PAYLOAD_BYTE  = 3,
  parameter int         PAYLOAD_BYTES = 16,
  parameter int         CNT_W         = 16
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [8*SIZE-1:0]          fifo_data,
  output logic                       rd_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 opcode,
  output logic [7:0]                 payload_len,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       err_pulse,
  output logic [1:0]                 err_code,
  output logic [CNT_W-1:0]           err_count
);

`ifdef PKT_PARSER_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SKIP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t                     state_q, state_d;
  logic                       rd_en_q, rd_en_d;
  logic                       out_valid_q, out_valid_d;
  logic [7:0]                 opcode_q, opcode_d;
  logic [7:0]                 payload_len_q, payload_len_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;

  logic [7:0]                 hdr_magic;
  logic [7:0]                 hdr_len;
  logic [7:0]                 hdr_opcode;
  logic [8*PAYLOAD_BYTES-1:0] win;
  logic [8*PAYLOAD_BYTES-1:0] win_masked;
  logic [1:0]                 hdr_flags;
  logic                       pkt_ok;

  assign hdr_magic  = fifo_data[8*MAGIC_BYTE +: 8];
  assign hdr_len    = fifo_data[8*LEN_BYTE +: 8];
  assign hdr_opcode = fifo_data[8*OPCODE_BYTE +: 8];
  assign win        = fifo_data[8*PAYLOAD_BYTE +: 8*PAYLOAD_BYTES];
  assign hdr_flags  = {int'(hdr_len) > PAYLOAD_BYTES, hdr_magic != MAGIC};

  // Bytes outside the parsed fields (and the flags when checks are off) are
  // deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{fifo_data, hdr_flags};

  // A length beyond the window keeps every byte, which is the same as
  // clamping the length to PAYLOAD_BYTES for masking.
  always_comb begin
    win_masked = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (i < int'(hdr_len)) win_masked[8*i +: 8] = win[8*i +: 8];
    end
  end

`ifdef PKT_PARSER_CHECK_EN
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign pkt_ok    = (hdr_flags == 2'b00);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
`else
  assign pkt_ok    = 1'b1;
  assign err_pulse = 1'b0;
  assign err_code  = 2'b00;
  assign err_count = '0;
`endif

  always_comb begin
    state_d       = state_q;
    rd_en_d       = 1'b0;
    out_valid_d   = out_valid_q;
    opcode_d      = opcode_q;
    payload_len_d = payload_len_q;
    payload_d     = payload_q;
`ifdef PKT_PARSER_CHECK_EN
    err_pulse_d   = 1'b0;
    err_code_d    = err_code_q;
    err_count_d   = err_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          if (pkt_ok) begin
            out_valid_d   = 1'b1;
            opcode_d      = hdr_opcode;
            payload_len_d = hdr_len;
            payload_d     = win_masked;
            state_d       = HOLD;
          end
`ifdef PKT_PARSER_CHECK_EN
          else begin
            err_pulse_d = 1'b1;
            err_code_d  = hdr_flags;
            err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
            state_d     = SKIP;
          end
`endif
        end
      end
      // The FIFO head is not looked at here; the pop issued on entry lands
      // during this state.
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef PKT_PARSER_CHECK_EN
      // One dead cycle so fifo_empty reflects the pop before the next look.
      SKIP: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_en_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      opcode_q      <= '0;
      payload_len_q <= '0;
      payload_q     <= '0;
`ifdef PKT_PARSER_CHECK_EN
      err_pulse_q   <= 1'b0;
      err_code_q    <= 2'b00;
      err_count_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rd_en_q       <= rd_en_d;
      out_valid_q   <= out_valid_d;
      opcode_q      <= opcode_d;
      payload_len_q <= payload_len_d;
      payload_q     <= payload_d;
`ifdef PKT_PARSER_CHECK_EN
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      err_count_q   <= err_count_d;
`endif
    end
  end

  assign rd_en       = rd_en_q;
  assign out_valid   = out_valid_q;
  assign opcode      = opcode_q;
  assign payload_len = payload_len_q;
  assign payload     = payload_q;

endmodule

// File: tb/tb_packet_parser.sv
// tb/tb_packet_parser.sv - self-checking bench for packet_parser
module tb_packet_parser;
  localparam int         SIZE  = 32;
  localparam int         PB    = 16;
  localparam int         PBYTE = 3;
  localparam int         CNT_W = 2;
  localparam logic [7:0] MAGIC = 8'hA5;
`ifdef PKT_PARSER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [8*SIZE-1:0] pkt_t;
  typedef logic [8*PB-1:0]   w_t;

  logic             CLK = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty;
  pkt_t             fifo_data;
  logic             rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       opcode;
  logic [7:0]       payload_len;
  w_t               payload;
  logic             err_pulse;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] err_count;

  packet_parser #(
    .SIZE(SIZE), .MAGIC_BYTE(0), .MAGIC(MAGIC), .LEN_BYTE(1), .OPCODE_BYTE(2),
    .PAYLOAD_BYTE(PBYTE), .PAYLOAD_BYTES(PB), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .payload_len(payload_len), .payload(payload),
    .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  pkt_t       fifo_q[$];
  int         pops = 0;
  int         passed = 0;
  int         failed = 0;
  int         total = 0;
  int         exp_cnt = 0;
  logic [7:0] last_op = '0;
  logic [7:0] last_len = '0;
  w_t         last_pl = '0;
  logic [1:0] last_code = '0;

  function automatic void refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  function automatic logic [7:0] get_byte(pkt_t p, int k);
    return p[8*k +: 8];
  endfunction

  function automatic pkt_t make_pkt(logic [7:0] magic, logic [7:0] len, logic [7:0] op);
    pkt_t p;
    for (int k = 0; k < SIZE; k++) p[8*k +: 8] = 8'($urandom);
    p[8*0 +: 8] = magic;
    p[8*1 +: 8] = len;
    p[8*2 +: 8] = op;
    return p;
  endfunction

  function automatic logic [1:0] model_flags(pkt_t p);
    int n;
    n = int'(get_byte(p, 1));
    return {n > PB, get_byte(p, 0) != MAGIC};
  endfunction

  function automatic w_t model_payload(pkt_t p);
    w_t w;
    int n;
    w = '0;
    n = int'(get_byte(p, 1));
    if (n > PB) n = PB;
    for (int i = 0; i < n; i++) w[8*i +: 8] = get_byte(p, PBYTE + i);
    return w;
  endfunction

  task automatic check(string tag, w_t obs, w_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the FIFO pops just after a rising
  // edge at which rd_en was high.
  task automatic tick();
    logic do_pop;
    do_pop = rd_en;
    @(posedge CLK);
    #1;
    if (do_pop) begin
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    refresh();
    @(negedge CLK);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt   = 0;
    last_op   = '0;
    last_len  = '0;
    last_pl   = '0;
    last_code = '0;
  endtask

  // One packet through an idle parser with an empty FIFO; a good packet is
  // held for `stall` cycles with out_ready low before being accepted.
  task automatic send(pkt_t p, int stall);
    bit   bad;
    w_t   exp_pl;
    int   pops0;
    bad    = CHK && (model_flags(p) != 2'b00);
    exp_pl = model_payload(p);
    pops0  = pops;
    out_ready = (stall == 0);
    fifo_q.push_back(p);
    refresh();
    tick();
    check("rd_en_rise", w_t'(rd_en), w_t'(1));
    if (bad) begin
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      last_code = model_flags(p);
      check("err_pulse", w_t'(err_pulse), w_t'(1));
      check("err_code", w_t'(err_code), w_t'(last_code));
      check("err_count", w_t'(err_count), w_t'(exp_cnt));
      check("err_no_valid", w_t'(out_valid), w_t'(0));
      check("err_opcode_kept", w_t'(opcode), w_t'(last_op));
      check("err_len_kept", w_t'(payload_len), w_t'(last_len));
      check("err_payload_kept", payload, last_pl);
      tick();
      check("err_pulse_1cyc", w_t'(err_pulse), w_t'(0));
      check("err_rd_en_1cyc", w_t'(rd_en), w_t'(0));
      check("err_code_held", w_t'(err_code), w_t'(last_code));
    end else begin
      check("out_valid", w_t'(out_valid), w_t'(1));
      check("good_no_err", w_t'(err_pulse), w_t'(0));
      check("opcode", w_t'(opcode), w_t'(get_byte(p, 2)));
      check("payload_len", w_t'(payload_len), w_t'(get_byte(p, 1)));
      check("payload", payload, exp_pl);
      check("good_err_count", w_t'(err_count), w_t'(exp_cnt));
      check("good_err_code", w_t'(err_code), w_t'(last_code));
      for (int k = 0; k < stall; k++) begin
        tick();
        check("hold_valid", w_t'(out_valid), w_t'(1));
        check("hold_no_pop", w_t'(rd_en), w_t'(0));
        check("hold_opcode", w_t'(opcode), w_t'(get_byte(p, 2)));
        check("hold_payload", payload, exp_pl);
      end
      out_ready = 1'b1;
      tick();
      check("valid_drop", w_t'(out_valid), w_t'(0));
      check("rd_en_drop", w_t'(rd_en), w_t'(0));
      last_op  = get_byte(p, 2);
      last_len = get_byte(p, 1);
      last_pl  = exp_pl;
    end
    check("one_pop", w_t'(pops - pops0), w_t'(1));
  endtask

  initial begin
    pkt_t p;
    pkt_t p2;
    pkt_t b[4];
    int   hs;
    int   pops0;

    out_ready = 1'b0;
    refresh();

    // Reset values while held and just after release with an empty FIFO.
    tick();
    check("rst_rd_en", w_t'(rd_en), w_t'(0));
    check("rst_out_valid", w_t'(out_valid), w_t'(0));
    check("rst_opcode", w_t'(opcode), w_t'(0));
    check("rst_payload_len", w_t'(payload_len), w_t'(0));
    check("rst_payload", payload, w_t'(0));
    check("rst_err_pulse", w_t'(err_pulse), w_t'(0));
    check("rst_err_code", w_t'(err_code), w_t'(0));
    check("rst_err_count", w_t'(err_count), w_t'(0));
    reset_dut();
    tick();
    check("idle_empty_no_pop", w_t'(rd_en), w_t'(0));
    check("idle_empty_no_valid", w_t'(out_valid), w_t'(0));

    // Reference packet: A5, len 4, opcode 3C, payload bytes 11, 12, ...
    p = make_pkt(MAGIC, 8'd4, 8'h3C);
    for (int i = 0; i < PB; i++) p[8*(PBYTE + i) +: 8] = 8'(8'h11 + i);
    send(p, 0);
    check("ref_payload", payload, w_t'(128'h14131211));
    send(p, 5);
    check("ref_stall_payload", payload, w_t'(128'h14131211));

    // Length boundaries: zero, full window, one past the window.
    send(make_pkt(MAGIC, 8'd0, 8'h01), 0);
    check("len0_zero", payload, w_t'(0));
    p = make_pkt(MAGIC, 8'(PB), 8'h02);
    send(p, 1);
    check("len_full", payload, p[8*PBYTE +: 8*PB]);
    send(make_pkt(MAGIC, 8'(PB + 1), 8'h03), 0);

    // Both header checks failing at once.
    send(make_pkt(8'h00, 8'd20, 8'h04), 0);

    // Back-to-back good packets with out_ready high.
    for (int i = 0; i < 4; i++) begin
      b[i] = make_pkt(MAGIC, 8'($urandom_range(0, PB)), 8'(8'h40 + i));
      fifo_q.push_back(b[i]);
    end
    refresh();
    out_ready = 1'b1;
    hs    = 0;
    pops0 = pops;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("burst_rd_en", w_t'(rd_en), w_t'((c % 2) == 0));
      if ((c % 2) == 0) begin
        check("burst_opcode", w_t'(opcode), w_t'(get_byte(b[c/2], 2)));
        check("burst_payload", payload, model_payload(b[c/2]));
      end
      if (out_valid && out_ready) hs++;
    end
    check("burst_handshakes", w_t'(hs), w_t'(4));
    check("burst_pops", w_t'(pops - pops0), w_t'(4));
    check("burst_err_count", w_t'(err_count), w_t'(exp_cnt));
    last_op  = get_byte(b[3], 2);
    last_len = get_byte(b[3], 1);
    last_pl  = model_payload(b[3]);

    // Counter saturation from a fresh reset.
    reset_dut();
    for (int i = 0; i < 5; i++) send(make_pkt(8'h00, 8'd20, 8'(i)), 0);

    // Randomised mix of good and malformed packets.
    for (int i = 0; i < 24; i++) begin
      send(make_pkt(($urandom_range(0, 3) == 0) ? 8'($urandom) : MAGIC,
                    8'($urandom_range(0, PB + 4)), 8'($urandom)),
           $urandom_range(0, 3));
    end

    // Asynchronous reset between edges while a packet is held.
    p = make_pkt(MAGIC, 8'd5, 8'h77);
    out_ready = 1'b0;
    fifo_q.push_back(p);
    refresh();
    tick();
    check("pre_rst_valid", w_t'(out_valid), w_t'(1));
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rd_en", w_t'(rd_en), w_t'(0));
    check("async_out_valid", w_t'(out_valid), w_t'(0));
    check("async_opcode", w_t'(opcode), w_t'(0));
    check("async_payload_len", w_t'(payload_len), w_t'(0));
    check("async_payload", payload, w_t'(0));
    check("async_err_pulse", w_t'(err_pulse), w_t'(0));
    check("async_err_code", w_t'(err_code), w_t'(0));
    check("async_err_count", w_t'(err_count), w_t'(0));
    p2 = make_pkt(MAGIC, 8'd2, 8'h99);
    fifo_q.push_back(p2);
    refresh();
    pops0 = pops;
    tick();
    check("rst_no_pop", w_t'(rd_en), w_t'(0));
    check("rst_no_pop_cnt", w_t'(pops - pops0), w_t'(0));
    rst = 1'b0;
    tick();
    check("post_rst_pop", w_t'(rd_en), w_t'(1));
    check("post_rst_valid", w_t'(out_valid), w_t'(1));
    check("post_rst_opcode", w_t'(opcode), w_t'(8'h99));
    check("post_rst_payload", payload, model_payload(p2));
    out_ready = 1'b1;
    tick();
    check("post_rst_accept", w_t'(out_valid), w_t'(0));
    check("post_rst_fifo_empty", w_t'(fifo_empty), w_t'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
